// File: rtl/bus_pkg.sv
// Shared constants and helpers for the bus arbiter/mux slice.
package bus_pkg;

  localparam int ARB_FIXED  = 0;
  localparam int ARB_RR     = 1;
  localparam int CONF_CNT_W = 16;

  // Number of bits needed to index 'value' items (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_rr_priority_encoder.sv
// Wrapping priority encoder: first set req bit at or after 'start'.
module bus_rr_priority_encoder
  import bus_pkg::*;
#(
  parameter int N     = 25,
  parameter int SEL_W = clog2(N)
) (
  input  logic [SEL_W-1:0] start,
  input  logic [N-1:0]     req,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [SEL_W-1:0] w_base;
  logic [SEL_W:0]   w_sum;
  logic [SEL_W:0]   w_pos;

  // Scan offsets from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    w_base  = (int'(start) < N) ? start : '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, w_base} + (SEL_W+1)'(k);
      w_pos = (w_sum >= (SEL_W+1)'(N)) ? (w_sum - (SEL_W+1)'(N)) : w_sum;
      if (req[w_pos[SEL_W-1:0]]) begin
        gnt_idx = w_pos[SEL_W-1:0];
        gnt_any = 1'b1;
      end else begin
        gnt_idx = gnt_idx;
        gnt_any = gnt_any;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered N-source bus arbiter/mux with multi-driver detection.
// Optional saturating conflict counter enabled by BUS_CONFLICT_CHECK_EN.
module bus_arbiter_mux
  import bus_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int N_SRC     = 25,
  parameter int ARB_MODE  = 0,
  parameter int HOLD_LAST = 1,
  localparam int SEL_W    = clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [N_SRC-1:0]        src_oe,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [DATA_W-1:0]       bus_out,
  output logic                    bus_valid,
  output logic [SEL_W-1:0]        bus_sel,
  output logic                    bus_conflict,
  output logic [CONF_CNT_W-1:0]   conflict_cnt
);

  logic [DATA_W-1:0] w_src [N_SRC];
  logic [SEL_W-1:0]  w_start;
  logic [SEL_W-1:0]  w_gnt_idx;
  logic              w_gnt_any;
  logic              w_multi;

  logic [DATA_W-1:0] r_bus_out;
  logic              r_bus_valid;
  logic [SEL_W-1:0]  r_bus_sel;
  logic              r_bus_conflict;
  logic [SEL_W-1:0]  r_rr_ptr;

  // Unpack the flattened source data into an indexable array.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      w_src[i] = src_data[i*DATA_W +: DATA_W];
    end
  end

  assign w_start = (ARB_MODE == ARB_RR) ? r_rr_ptr : '0;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi = |(src_oe & (src_oe - {{(N_SRC-1){1'b0}}, 1'b1}));

  bus_rr_priority_encoder #(
    .N     (N_SRC),
    .SEL_W (SEL_W)
  ) u_enc (
    .start   (w_start),
    .req     (src_oe),
    .gnt_idx (w_gnt_idx),
    .gnt_any (w_gnt_any)
  );

  // Bus output registers and round-robin pointer.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_bus_out      <= '0;
      r_bus_valid    <= 1'b0;
      r_bus_sel      <= '0;
      r_bus_conflict <= 1'b0;
      r_rr_ptr       <= '0;
    end else begin
      r_bus_conflict <= w_multi;
      if (w_gnt_any) begin
        r_bus_out   <= w_src[w_gnt_idx];
        r_bus_sel   <= w_gnt_idx;
        r_bus_valid <= 1'b1;
        r_rr_ptr    <= (w_gnt_idx == SEL_W'(N_SRC - 1)) ? '0 : (w_gnt_idx + SEL_W'(1));
      end else begin
        r_bus_valid <= 1'b0;
        if (HOLD_LAST == 0) begin
          r_bus_out <= '0;
        end
      end
    end
  end

  assign bus_out      = r_bus_out;
  assign bus_valid    = r_bus_valid;
  assign bus_sel      = r_bus_sel;
  assign bus_conflict = r_bus_conflict;

`ifdef BUS_CONFLICT_CHECK_EN
  logic [CONF_CNT_W-1:0] r_conflict_cnt;

  // Saturating count of sampled multi-driver cycles.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_conflict_cnt <= '0;
    end else if (w_multi && (r_conflict_cnt != {CONF_CNT_W{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + CONF_CNT_W'(1);
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`else
  assign conflict_cnt = '0;
`endif

endmodule
